// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: instruction layout, opcodes,
// and the arbiter FSM state encoding.
package alu_pkg;

  localparam int OPC_W   = 2;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = OPC_W + 2 * DATA_W;

  localparam logic [OPC_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OPC_W-1:0] OP_XOR  = 2'b01;
  localparam logic [OPC_W-1:0] OP_NAND = 2'b10;
  localparam logic [OPC_W-1:0] OP_FUNC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } instr_t;

endpackage

// File: rtl/main_design.sv
// Combinational 8-bit ALU: decodes {opcode, a, b} and produces a modulo-256
// result with no carry or borrow out.
module main_design
  import alu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [DATA_W-1:0]  result_o
);

  instr_t ins;
  assign ins = instr_t'(instr_i);

  always_comb begin
    result_o = '0;
    case (ins.opcode)
      OP_ADD:  result_o = ins.a + ins.b;
      OP_XOR:  result_o = ins.a ^ ins.b;
      OP_NAND: result_o = ~(ins.a & ins.b);
      OP_FUNC: result_o = (ins.a | ins.b) - ins.b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU: accepts one
// instruction at a time, executes it, and returns a tagged registered response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [INSTR_W-1:0] req0_instr,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               id_q, id_d;
  logic               last_id_q, last_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic [DATA_W-1:0]  alu_result;
  logic               any_valid;
  logic               grant_id;

  main_design u_alu (
    .instr_i  (instr_q),
    .result_o (alu_result)
  );

  // On contention the requester that did not win last time gets the grant.
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    instr_d    = instr_q;
    id_d       = id_q;
    last_id_d  = last_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          instr_d    = grant_id ? req1_instr : req0_instr;
          id_d       = grant_id;
          last_id_d  = grant_id;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = alu_result;
        rsp_id_d   = id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        // Response registers are only written in EXEC, so they hold steady
        // for as long as the consumer stalls here.
        if (rsp_ready) begin
          if (rsp_id_q) cnt1_d = cnt1_q + CNT_W'(1);
          else          cnt0_d = cnt0_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      id_q       <= 1'b0;
      last_id_q  <= 1'b1;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      id_q       <= id_d;
      last_id_q  <= last_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model; a second CNT_W=2 copy checks wrap.
module tb_alu_arbiter;

  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [17:0] req0_instr, req1_instr;

  logic             req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [7:0]       rsp_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
  logic [7:0] s_rsp_data;
  logic [1:0] s_cnt0, s_cnt1;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_arbiter #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(s_req1_ready),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id),
    .rsp_ready(rsp_ready), .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference ALU from the operation table; opcode 11 uses the identity
  // (a|b)-b == a & ~b.
  function automatic logic [7:0] ref_alu(input logic [17:0] ins);
    int a, b;
    a = int'(ins[15:8]);
    b = int'(ins[7:0]);
    case (ins[17:16])
      2'b00:   return 8'((a + b) % 256);
      2'b01:   return 8'(a ^ b);
      2'b10:   return 8'(255 - (a & b));
      default: return 8'(a & (255 - b));
    endcase
  endfunction

  // Transaction-level model: one operation in flight, aged in cycles since
  // acceptance; the result is visible from the second cycle after acceptance.
  bit         m_inflight;
  int         m_age;
  bit         m_id;
  logic [7:0] m_res;
  bit         m_last;
  int         m_cnt[2];
  logic [7:0] last_rsp;
  logic       last_rsp_id;
  int         grants[$];

  task automatic model_reset();
    m_inflight = 0;
    m_age      = 0;
    m_last     = 1;
    m_cnt[0]   = 0;
    m_cnt[1]   = 0;
  endtask

  task automatic cycle(input logic v0, input logic [17:0] i0,
                       input logic v1, input logic [17:0] i1, input logic rr);
    logic e_r0, e_r1, e_rv;
    req0_valid = v0; req0_instr = i0;
    req1_valid = v1; req1_instr = i1;
    rsp_ready  = rr;
    #1;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (!m_inflight) begin
      if (v0 && v1) begin
        e_r0 = !m_last;
        e_r0 = ~e_r0 ? 1'b0 : 1'b1;
        e_r0 = (m_last == 1);
        e_r1 = (m_last == 0);
      end else begin
        e_r0 = v0;
        e_r1 = v1;
      end
    end
    e_rv = m_inflight && (m_age >= 1);

    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    check("rsp_valid", rsp_valid, e_rv);
    check("busy", busy, m_inflight);
    check("cnt0", cnt0, m_cnt[0] % 256);
    check("cnt1", cnt1, m_cnt[1] % 256);
    check("small_ready", {s_req0_ready, s_req1_ready}, {e_r0, e_r1});
    check("small_valid_busy", {s_rsp_valid, s_busy}, {e_rv, m_inflight});
    check("small_cnt0", s_cnt0, m_cnt[0] % 4);
    check("small_cnt1", s_cnt1, m_cnt[1] % 4);
    if (e_rv) begin
      check("rsp_data", rsp_data, m_res);
      check("rsp_id", rsp_id, m_id);
      check("small_rsp", {s_rsp_id, s_rsp_data}, {m_id, m_res});
    end
    if (rsp_valid) begin
      last_rsp    = rsp_data;
      last_rsp_id = rsp_id;
    end
    if (req0_ready || req1_ready) grants.push_back(int'(req1_ready));

    @(posedge clk);
    if (e_rv) begin
      if (rr) begin
        m_cnt[m_id]++;
        m_inflight = 0;
      end
    end else if (m_inflight) begin
      m_age++;
    end else if (e_r0 || e_r1) begin
      m_id       = e_r1;
      m_res      = ref_alu(e_r1 ? i1 : i0);
      m_last     = e_r1;
      m_inflight = 1;
      m_age      = 0;
    end
    #1;
  endtask

  task automatic run_op(input logic v0, input logic [17:0] i0,
                        input logic v1, input logic [17:0] i1);
    cycle(v0, i0, v1, i1, 1'b1);
    cycle(1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    cycle(1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_instr = '0;   req1_instr = '0;
    rsp_ready  = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_cnt", {cnt0, cnt1}, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_small", {s_rsp_valid, s_busy, s_cnt0, s_cnt1}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] x0, x1;
    int wait_cycles;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_instr = '0;   req1_instr = '0;
    rsp_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request from requester 0.
    run_op(1'b1, {2'b00, 8'h20, 8'h1F}, 1'b0, 18'h0);
    check("single_data", last_rsp, 8'h3F);
    check("single_id", last_rsp_id, 0);
    check("single_cnt0", cnt0, 1);

    // Contention right after reset: requester 0 first, then strict alternation.
    do_reset();
    grants.delete();
    repeat (12) cycle(1'b1, {2'b01, 8'h01, 8'h00}, 1'b1, {2'b10, 8'hAA, 8'h55}, 1'b1);
    check("cont_ngrants", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) check("cont_grant", grants[k], k % 2);
    check("cont_cnt", {cnt0, cnt1}, {8'd2, 8'd2});

    // Backpressure with both requesters asserting throughout.
    x0 = {2'b00, 8'h12, 8'h34};
    x1 = {2'b11, 8'hF0, 8'h3C};
    cycle(1'b1, x0, 1'b1, x1, 1'b0);
    cycle(1'b1, x0, 1'b1, x1, 1'b0);
    repeat (5) cycle(1'b1, x0, 1'b1, x1, 1'b0);
    check("bp_held_data", last_rsp, 8'h46);
    cycle(1'b1, x0, 1'b1, x1, 1'b1);
    check("bp_done", busy, 0);
    check("bp_cnt0", cnt0, 3);

    // Arithmetic edge cases.
    run_op(1'b0, 18'h0, 1'b1, {2'b11, 8'h1F, 8'h11});
    check("arith_func", last_rsp, 8'h0E);
    run_op(1'b1, {2'b00, 8'hFF, 8'h01}, 1'b0, 18'h0);
    check("arith_add_wrap", last_rsp, 8'h00);
    run_op(1'b0, 18'h0, 1'b1, {2'b11, 8'h00, 8'h01});
    check("arith_func_zero", last_rsp, 8'h00);

    // Narrow counter wrap on requester 1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_op(1'b0, 18'h0, 1'b1, {2'b01, 8'(k), 8'h5A});
      check("wrap_cnt1", s_cnt1, (k + 1) % 4);
    end

    // Reset while a response is being held.
    cycle(1'b1, {2'b10, 8'h0F, 8'hF0}, 1'b0, 18'h0, 1'b0);
    cycle(1'b0, 18'h0, 1'b0, 18'h0, 1'b0);
    cycle(1'b0, 18'h0, 1'b0, 18'h0, 1'b0);
    check("pre_reset_valid", rsp_valid, 1);
    do_reset();
    repeat (4) cycle(1'b0, 18'h0, 1'b0, 18'h0, 1'b1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 2500; n++) begin
      cycle($urandom_range(0, 2) != 0, 18'($urandom), $urandom_range(0, 2) != 0,
            18'($urandom), $urandom_range(0, 9) < 7);
    end

    // Drain any in-flight operation within a bounded number of cycles.
    wait_cycles = 0;
    while (m_inflight && wait_cycles < 10) begin
      cycle(1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
      wait_cycles++;
    end
    check("drain_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
